cmp_stream_tracker: RTL

Parametrised, pipelined successor to the team's 4-bit equal/greater/less/max comparators. Accepts a stream of (x, y) operand pairs over a valid/ready handshake and produces registered eq/gt/lt flags and a mode-selected pair result for each pair. Tracks the running max, running min and beat count of the pair results across a packet delimited by in_last. Sits between operand sources and downstream consumers in the Project1 datapath and replaces the combinational compare modules wherever results must be buffered.

---
 rtl/cmp_stream_if.sv | 33 +++
 rtl/cmp_stream_tracker.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cmp_stream_if.sv
// Operand/result stream bundle for cmp_stream_tracker.
// slave: the tracker side. master: the operand source / result consumer side.
interface cmp_stream_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [1:0]       mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] run_max;
  logic [WIDTH-1:0] run_min;
  logic [CNT_W-1:0] count;
  logic             out_last;

  modport slave (
    input  in_valid, x, y, mode, in_last, out_ready,
    output in_ready, out_valid, eq, gt, lt, res, run_max, run_min, count, out_last
  );

  modport master (
    output in_valid, x, y, mode, in_last, out_ready,
    input  in_ready, out_valid, eq, gt, lt, res, run_max, run_min, count, out_last
  );
endinterface

// File: rtl/cmp_stream_tracker.sv
// Streaming comparator with per-packet running max/min/beat count.
// Single-entry registered output; one beat per cycle while out_ready is high.
// Build option: define CMP_SIGNED_EN for two's-complement ordering of x, y,
// res selection and running max/min (eq, handshake, counter, FSM unchanged).
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no packet open; next accepted beat starts one
// RUN   | packet open; accepted beats fold into stats
module cmp_stream_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  cmp_stream_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_t           state_q, state_nxt;
  logic             valid_q;
  logic             eq_q, gt_q, lt_q, last_q;
  logic [WIDTH-1:0] res_q, max_q, min_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             in_ready;
  logic             x_eq, x_gt, x_lt;
  logic [WIDTH-1:0] res_d, max_d, min_d;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign x_eq = (bus.x == bus.y);
  assign x_lt = less(bus.x, bus.y);
  assign x_gt = less(bus.y, bus.x);

  // State register: reset discards any open packet.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Next state: a packet opens on a non-last beat and closes on its last beat.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (accept && !bus.in_last) state_nxt = RUN;
      RUN:  if (accept && bus.in_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the beat being accepted; IDLE seeds stats, RUN folds them.
  always_comb begin
    res_d = bus.y;
    case (bus.mode)
      2'd0: res_d = x_gt ? bus.x : bus.y;
      2'd1: res_d = x_lt ? bus.x : bus.y;
      2'd2: res_d = bus.x;
      2'd3: res_d = bus.y;
      default: res_d = bus.y;
    endcase
    max_d = res_d;
    min_d = res_d;
    cnt_d = CNT_W'(1);
    if (state_q == RUN) begin
      max_d = less(max_q, res_d) ? res_d : max_q;
      min_d = less(res_d, min_q) ? res_d : min_q;
      cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Output register: load on accept, drop valid on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      last_q  <= 1'b0;
      res_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      eq_q    <= x_eq;
      gt_q    <= x_gt;
      lt_q    <= x_lt;
      last_q  <= bus.in_last;
      res_q   <= res_d;
      max_q   <= max_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.res       = res_q;
  assign bus.run_max   = max_q;
  assign bus.run_min   = min_q;
  assign bus.count     = cnt_q;
  assign bus.out_last  = last_q;

endmodule
